// File: rtl/led_matrix_pkg.sv
// Shared LED matrix constants: geometry, row-index width and scan FSM encodings.
// Also consumed by the CPU-side peripheral decode.
package led_matrix_pkg;

    localparam int MATRIX_DIM = 8;
    localparam int ROW_IDX_W  = $clog2(MATRIX_DIM);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_matrix_scanner.sv
// Double-buffered 8x8 LED matrix row scanner with frame-synchronous buffer swap.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_BLANK | all rows off, columns unlit, for BLANK_CYCLES before a row
//   ST_DRIVE | row r selected, columns show front[r], for ROW_PERIOD cycles
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROW_PERIOD     = 27000,
    parameter int BLANK_CYCLES   = 64,
    parameter bit COL_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrEn,
    input  logic [ROW_IDX_W-1:0]  wrRow,
    input  logic [MATRIX_DIM-1:0] wrData,
    input  logic                  swapReq,
    output logic                  swapPending,
    output logic                  swapDone,
    output logic [MATRIX_DIM-1:0] matrixRow,
    output logic [MATRIX_DIM-1:0] matrixCol
);

    localparam int CNT_MAX = max_int(ROW_PERIOD, BLANK_CYCLES) - 1;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      DRIVE_LAST = CNT_W'(ROW_PERIOD - 1);
    localparam logic [ROW_IDX_W-1:0]  ROW_LAST   = ROW_IDX_W'(MATRIX_DIM - 1);
    localparam logic [MATRIX_DIM-1:0] ROW_ONE    = MATRIX_DIM'(1);
    localparam logic [MATRIX_DIM-1:0] COL_MASK   = COL_ACTIVE_LOW ? '1 : '0;

    logic [0:0]            state;
    logic [ROW_IDX_W-1:0]  r;
    logic [CNT_W-1:0]      cnt;
    logic [MATRIX_DIM-1:0] back_buf  [MATRIX_DIM];
    logic [MATRIX_DIM-1:0] front_buf [MATRIX_DIM];
    logic                  frame_end;

    assign frame_end = (state == ST_DRIVE) && (r == ROW_LAST) && (cnt == DRIVE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_BLANK;
            r     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= ST_DRIVE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (cnt == DRIVE_LAST) begin
                        state <= ST_BLANK;
                        r     <= r + ROW_IDX_W'(1);
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // The copy reads back_buf before this edge's write lands, so a colliding
    // write only shows up after the following swap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            swapPending <= 1'b0;
            swapDone    <= 1'b0;
            for (int i = 0; i < MATRIX_DIM; i++) begin
                back_buf[i]  <= '0;
                front_buf[i] <= '0;
            end
        end else begin
            swapDone <= 1'b0;
            if (wrEn) begin
                back_buf[wrRow] <= wrData;
            end
            if (frame_end && (swapPending || swapReq)) begin
                for (int i = 0; i < MATRIX_DIM; i++) begin
                    front_buf[i] <= back_buf[i];
                end
                swapPending <= 1'b0;
                swapDone    <= 1'b1;
            end else if (swapReq) begin
                swapPending <= 1'b1;
            end
        end
    end

    always_comb begin
        matrixRow = '0;
        matrixCol = COL_MASK;
        if (state == ST_DRIVE) begin
            matrixRow = ROW_ONE << r;
            matrixCol = front_buf[r] ^ COL_MASK;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench: timeline/buffer reference model plus directed and random stimulus.
module tb_led_matrix_scanner;

    localparam int RP    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = RP + BC;
    localparam int FRAME = 8 * SLOT;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wrEn = 1'b0;
    logic [2:0] wrRow = '0;
    logic [7:0] wrData = '0;
    logic       swapReq = 1'b0;
    logic       swapPending, swapDone;
    logic [7:0] matrixRow, matrixCol;

    led_matrix_scanner #(
        .ROW_PERIOD    (RP),
        .BLANK_CYCLES  (BC),
        .COL_ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wrEn       (wrEn),
        .wrRow      (wrRow),
        .wrData     (wrData),
        .swapReq    (swapReq),
        .swapPending(swapPending),
        .swapDone   (swapDone),
        .matrixRow  (matrixRow),
        .matrixCol  (matrixCol)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference: m_t = edges since reset release; position in frame fixes row/phase.
    logic [7:0] m_front [8];
    logic [7:0] m_back  [8];
    bit         m_pend;
    bit         m_done;
    int         m_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t (m_t=%0d)", tag, obs, exp, $time, m_t);
        end
    endtask

    function automatic int m_row();
        return (m_t % FRAME) / SLOT;
    endfunction

    function automatic bit m_drive();
        return (m_t % SLOT) >= BC;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_front[i] = '0;
            m_back[i]  = '0;
        end
        m_pend = 0;
        m_done = 0;
        m_t    = 0;
    endtask

    task automatic check_outputs();
        logic [7:0] one;
        logic [7:0] exp_row;
        logic [7:0] exp_col;
        one     = 8'h01;
        exp_row = m_drive() ? (one << m_row()) : 8'h00;
        exp_col = m_drive() ? ~m_front[m_row()] : 8'hFF;
        chk("row", matrixRow, exp_row);
        chk("col", matrixCol, exp_col);
        chk("pend", swapPending, m_pend);
        chk("done", swapDone, m_done);
    endtask

    task automatic step(input bit we, input logic [2:0] row, input logic [7:0] d, input bit sreq);
        wrEn    = we;
        wrRow   = row;
        wrData  = d;
        swapReq = sreq;
        check_outputs();
        @(posedge clk);
        m_done = 0;
        if ((m_t % FRAME) == FRAME - 1 && (m_pend || sreq)) begin
            m_front = m_back;
            m_pend  = 0;
            m_done  = 1;
        end else if (sreq) begin
            m_pend = 1;
        end
        if (we) m_back[row] = d;
        m_t++;
        #1;
        wrEn    = 1'b0;
        swapReq = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 3'd0, 8'h00, 0);
    endtask

    task automatic run_to(input int pos);
        for (int k = 0; k < FRAME && (m_t % FRAME) != pos; k++) idle(1);
    endtask

    initial begin
        int e;
        model_reset();

        // reset held
        #12;
        chk("rst_row", matrixRow, 8'h00);
        chk("rst_col", matrixCol, 8'hFF);
        check_outputs();
        @(negedge clk);
        rst = 1'b1;

        // first DRIVE of row 0 after BLANK_CYCLES edges
        e = 0;
        while (matrixRow !== 8'h01 && e < 10) begin
            idle(1);
            e++;
        end
        chk("first_drive_edges", e, BC);

        // frame length: from row-0 drive start to the next one
        e = 0;
        while (matrixRow === 8'h01 && e < 100) begin idle(1); e++; end
        while (matrixRow !== 8'h01 && e < 100) begin idle(1); e++; end
        chk("frame_len", e, FRAME);

        // write without swap: front untouched
        step(1, 3'd3, 8'hA5, 0);
        run_to(3 * SLOT + BC);
        chk("nowap_row3_col", matrixCol, 8'hFF);
        idle(FRAME);
        chk("noswap_pend", swapPending, 1'b0);

        // swap requested during row 2
        run_to(2 * SLOT + BC);
        step(0, 3'd0, 8'h00, 1);
        chk("swap_pend_set", swapPending, 1'b1);
        run_to(FRAME - 1);
        chk("swap_pend_hold", swapPending, 1'b1);
        idle(1);
        chk("swap_done_pulse", swapDone, 1'b1);
        chk("swap_pend_clr", swapPending, 1'b0);
        idle(1);
        chk("swap_done_once", swapDone, 1'b0);
        run_to(3 * SLOT + BC);
        chk("swap_row3_sel", matrixRow, 8'h08);
        chk("swap_row3_col", matrixCol, 8'h5A);

        // write colliding with boundary swap: copy sees pre-write back[0]=0
        run_to(FRAME - 1);
        step(1, 3'd0, 8'hFF, 1);
        run_to(BC);
        chk("coll_col_first", matrixCol, 8'hFF);
        step(0, 3'd0, 8'h00, 1);
        run_to(FRAME - 1);
        idle(1);
        run_to(BC);
        chk("coll_col_second", matrixCol, 8'h00);

        // randomized traffic against the model
        for (int k = 0; k < 700; k++) begin
            step($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                 8'($urandom), $urandom_range(0, 29) == 0);
        end

        // reset in the middle of row 5 DRIVE with a swap pending and back loaded
        run_to(4 * SLOT + BC);
        step(0, 3'd0, 8'h00, 1);
        for (int i = 0; i < 8; i++) step(1, 3'(i), 8'($urandom) | 8'h01, 0);
        run_to(5 * SLOT + BC + 1);
        chk("pre_rst_row5", matrixRow, 8'h20);
        rst = 1'b0;
        #1;
        chk("midrst_row", matrixRow, 8'h00);
        chk("midrst_col", matrixCol, 8'hFF);
        chk("midrst_pend", swapPending, 1'b0);
        chk("midrst_done", swapDone, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(2 * FRAME);
        chk("post_rst_pend", swapPending, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/led_matrix_scanner.md
LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 SHALL have parameter ROW_PERIOD, default 27000, meaning clk cycles each row is driven (≥1).
REQ-002 SHALL have parameter BLANK_CYCLES, default 64, meaning all-off clk cycles before each row (≥1).
REQ-003 SHALL have parameter COL_ACTIVE_LOW, default 1, meaning matrixCol lit level is 0 when 1, and 1 when 0.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wrEn  input  1  write strobe into back buffer.
REQ-007 SHALL have port wrRow  input  3  back-buffer row index.
REQ-008 SHALL have port wrData  input  8  row pixels, bit j = column j, 1 = lit.
REQ-009 SHALL have port swapReq  input  1  one-cycle pulse requesting back→front copy.
REQ-010 SHALL have port swapPending  output  1  swap requested, not yet performed.
REQ-011 SHALL have port swapDone  output  1  one-cycle pulse when copy performed.
REQ-012 SHALL have port matrixRow  output  8  one-hot active-high row select.
REQ-013 SHALL have port matrixCol  output  8  column drive, polarity per COL_ACTIVE_LOW.

Function
REQ-014 SHALL hold two 8x8 buffers: back (written by wrEn), front (displayed).
REQ-015 SHALL write back[wrRow] <= wrData on any clk edge with wrEn=1; writes never touch front.
REQ-016 SHALL run FSM states BLANK and DRIVE with scan row index r (0..7) and cycle counter cnt.
REQ-017 SHALL in BLANK count cnt 0..BLANK_CYCLES-1, then go to DRIVE, same r, cnt<=0.
REQ-018 SHALL in DRIVE count cnt 0..ROW_PERIOD-1, then go to BLANK, r<=r+1 mod 8 (7 wraps to 0), cnt<=0.
REQ-019 SHALL size cnt to hold max(ROW_PERIOD, BLANK_CYCLES)-1; no overflow.
REQ-020 SHALL derive outputs only from registered state (Moore): in DRIVE matrixRow = 1<<r, matrixCol = front[r] (inverted if COL_ACTIVE_LOW); in BLANK matrixRow = 0, matrixCol = all-unlit (0xFF if COL_ACTIVE_LOW, else 0x00).
REQ-021 SHALL set swapPending on swapReq=1; swapReq while pending is absorbed (no second swap).
REQ-022 SHALL define frame boundary as last DRIVE cycle of r=7; at that edge, if swapPending or swapReq, copy front <= back, clear swapPending, pulse swapDone next cycle.
REQ-023 SHALL on same-edge wrEn and swap copy pre-write back contents; the write lands in back only.
REQ-024 SHALL give frame length 8*(BLANK_CYCLES+ROW_PERIOD) cycles, never altered by writes or swaps.

Reset
REQ-025 SHALL on rst=0, immediately and independent of clk: state BLANK, r=0, cnt=0, both buffers 0, swapPending=0, swapDone=0, matrixRow=0, matrixCol all-unlit.
REQ-026 SHALL after rst deassertion start first DRIVE of row 0 after BLANK_CYCLES edges.
REQ-027 SHALL discard any pending swap and buffer contents on reset mid-operation.

Structure
REQ-028 SHALL place MATRIX_DIM=8, row-index width and FSM state encodings in shared header led_matrix_pkg, also used by CPU peripheral decode.
REQ-029 SHALL need no sub-module; counter and FSM inline, buffers as register arrays.

Verification (ROW_PERIOD=4, BLANK_CYCLES=2, COL_ACTIVE_LOW=1)
REQ-030 SHALL test reset: hold rst=0 -> matrixRow=0x00, matrixCol=0xFF; release -> matrixRow=0x01 exactly 2 cycles later, row sequence 0x01,0x02..0x80,0x01 with 48-cycle frame.
REQ-031 SHALL test write without swap: wrRow=3, wrData=0xA5 -> row-3 matrixCol stays 0xFF for full frame, swapPending=0.
REQ-032 SHALL test swap: swapReq in row 2 -> swapPending=1 until row-7 last DRIVE cycle, swapDone pulses once, following row-3 DRIVE shows matrixCol=0x5A.
REQ-033 SHALL test collision: wrEn(row 0, 0xFF) on same edge as boundary swap with back[0]=0x00 -> next row-0 matrixCol=0xFF; after second swap =0x00.
REQ-034 SHALL test reset mid-DRIVE row 5 with pending swap -> outputs inactive same cycle, swapPending=0, front all zero after release.
